sprite_motion_scheduler: RTL and testbench



---
 rtl/sprite_motion_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_sprite_motion_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_scheduler.sv
// Per-frame sprite motion / collision / background sequencer.
// Ports: Clk_50MHz, Rst_n, frame_tick, run -> x0..x2, bg_state, busy, commit, hit_count, overrun.
module sprite_motion_scheduler #(
  parameter int SCR_W     = 640,
  parameter int W0        = 60,
  parameter int W1        = 65,
  parameter int W2        = 80,
  parameter int X0_INIT   = 11,
  parameter int X1_INIT   = 101,
  parameter int X2_INIT   = 201,
  parameter int SPD0      = 2,
  parameter int SPD1      = 1,
  parameter int SPD2      = 3,
  parameter int BG_FRAMES = 60
) (
  input  logic       Clk_50MHz,
  input  logic       Rst_n,
  input  logic       frame_tick,
  input  logic       run,
  output logic [9:0] x0,
  output logic [9:0] x1,
  output logic [9:0] x2,
  output logic [1:0] bg_state,
  output logic       busy,
  output logic       commit,
  output logic [7:0] hit_count,
  output logic       overrun
);

  localparam int FW = $clog2(BG_FRAMES + 1);

  localparam logic [10:0] L_SCR = 11'(SCR_W);
  localparam logic [10:0] L_W0  = 11'(W0);
  localparam logic [10:0] L_W1  = 11'(W1);
  localparam logic [10:0] L_W2  = 11'(W2);
  localparam logic [10:0] L_S0  = 11'(SPD0);
  localparam logic [10:0] L_S1  = 11'(SPD1);
  localparam logic [10:0] L_S2  = 11'(SPD2);
  localparam logic [FW-1:0] L_FLAST = FW'(BG_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UPD0,
    S_UPD1,
    S_UPD2,
    S_COLL,
    S_COMMIT
  } state_t;

  state_t        r_state;
  logic [10:0]   r_s0;
  logic [10:0]   r_s1;
  logic [10:0]   r_s2;
  logic [2:0]    r_dir;
  logic          r_ovl;
  logic [FW-1:0] r_fcnt;
  logic [9:0]    r_x0;
  logic [9:0]    r_x1;
  logic [9:0]    r_x2;
  logic [1:0]    r_bg;
  logic          r_busy;
  logic          r_commit;
  logic [7:0]    r_hit;
  logic          r_ovr;

  logic          w_ovl;

  // Returns {new_dir, new_pos}; landing exactly on an edge keeps direction.
  function automatic logic [11:0] f_step(
    input logic [10:0] s,
    input logic        d,
    input logic [10:0] spd,
    input logic [10:0] w
  );
    logic [10:0] ns;
    logic        nd;
    ns = s;
    nd = d;
    if (d) begin
      if (s + spd + w > L_SCR) begin
        ns = L_SCR - w;
        nd = 1'b0;
      end else begin
        ns = s + spd;
      end
    end else begin
      if (s < spd) begin
        ns = '0;
        nd = 1'b1;
      end else begin
        ns = s - spd;
      end
    end
    return {nd, ns};
  endfunction

  assign w_ovl = (r_s0 < r_s1 + L_W1) && (r_s1 < r_s0 + L_W0);

  always_ff @(posedge Clk_50MHz) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_s0     <= 11'(X0_INIT);
      r_s1     <= 11'(X1_INIT);
      r_s2     <= 11'(X2_INIT);
      r_dir    <= 3'b111;
      r_ovl    <= 1'b0;
      r_fcnt   <= '0;
      r_x0     <= 10'(X0_INIT);
      r_x1     <= 10'(X1_INIT);
      r_x2     <= 10'(X2_INIT);
      r_bg     <= 2'd0;
      r_busy   <= 1'b0;
      r_commit <= 1'b0;
      r_hit    <= 8'd0;
      r_ovr    <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      // A tick seen in any non-idle state, including COMMIT, is dropped.
      if (frame_tick && run && r_state != S_IDLE)
        r_ovr <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (frame_tick && run) begin
            r_s0    <= {1'b0, r_x0};
            r_s1    <= {1'b0, r_x1};
            r_s2    <= {1'b0, r_x2};
            r_busy  <= 1'b1;
            r_state <= S_UPD0;
          end
        end
        S_UPD0: begin
          {r_dir[0], r_s0} <= f_step(r_s0, r_dir[0], L_S0, L_W0);
          r_state <= S_UPD1;
        end
        S_UPD1: begin
          {r_dir[1], r_s1} <= f_step(r_s1, r_dir[1], L_S1, L_W1);
          r_state <= S_UPD2;
        end
        S_UPD2: begin
          {r_dir[2], r_s2} <= f_step(r_s2, r_dir[2], L_S2, L_W2);
          r_state <= S_COLL;
        end
        S_COLL: begin
          // Only a new contact counts; bounce applies from next frame.
          if (w_ovl && !r_ovl) begin
            if (r_hit != 8'hFF)
              r_hit <= r_hit + 8'd1;
            r_dir[0] <= ~r_dir[0];
            r_dir[1] <= ~r_dir[1];
          end
          r_ovl   <= w_ovl;
          r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_x0     <= r_s0[9:0];
          r_x1     <= r_s1[9:0];
          r_x2     <= r_s2[9:0];
          r_commit <= 1'b1;
          r_busy   <= 1'b0;
          if (r_fcnt == L_FLAST) begin
            r_fcnt <= '0;
            r_bg   <= (r_bg == 2'd2) ? 2'd0 : r_bg + 2'd1;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign x0        = r_x0;
  assign x1        = r_x1;
  assign x2        = r_x2;
  assign bg_state  = r_bg;
  assign busy      = r_busy;
  assign commit    = r_commit;
  assign hit_count = r_hit;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_sprite_motion_scheduler.sv
// Scoreboard bench for sprite_motion_scheduler.
// Stimulus queues hand-computed frame results; a commit monitor checks them.
module tb_sprite_motion_scheduler;

  logic       clk;
  logic       Rst_n;
  logic       frame_tick;
  logic       run;
  logic [9:0] x0;
  logic [9:0] x1;
  logic [9:0] x2;
  logic [1:0] bg_state;
  logic       busy;
  logic       commit;
  logic [7:0] hit_count;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  sprite_motion_scheduler dut (
    .Clk_50MHz (clk),
    .Rst_n     (Rst_n),
    .frame_tick(frame_tick),
    .run       (run),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .bg_state  (bg_state),
    .busy      (busy),
    .commit    (commit),
    .hit_count (hit_count),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // m bits: 0=x0 1=x1 2=x2 3=hit 4=bg
  typedef struct {
    logic [4:0] m;
    int         f;
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] x2;
    logic [7:0] hit;
    logic [1:0] bg;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t exp_for(input int f);
    exp_t e;
    e.m = 5'b0; e.f = f;
    e.x0 = 0; e.x1 = 0; e.x2 = 0; e.hit = 0; e.bg = 0;
    if (f <= 30) begin e.m[3] = 1'b1; e.hit = 8'd0; end
    case (f)
      1:   begin e.m = 5'b11111; e.x0 = 13; e.x1 = 102; e.x2 = 204; end
      30:  begin e.m = 5'b01111; e.x0 = 71; e.x1 = 131; e.x2 = 291; end
      31:  begin e.m = 5'b01111; e.x0 = 73; e.x1 = 132; e.x2 = 294; e.hit = 1; end
      32:  begin e.m = 5'b01111; e.x0 = 71; e.x1 = 131; e.x2 = 297; e.hit = 1; end
      33:  begin e.m = 5'b01111; e.x0 = 69; e.x1 = 130; e.x2 = 300; e.hit = 1; end
      34:  begin e.m = 5'b01111; e.x0 = 67; e.x1 = 129; e.x2 = 303; e.hit = 1; end
      59:  begin e.m = 5'b10000; e.bg = 0; end
      60:  begin e.m = 5'b10000; e.bg = 1; end
      119: begin e.m = 5'b10100; e.x2 = 558; e.bg = 1; end
      120: begin e.m = 5'b10100; e.x2 = 560; e.bg = 2; end
      121: begin e.m = 5'b10100; e.x2 = 557; e.bg = 2; end
      179: begin e.m = 5'b10000; e.bg = 2; end
      180: begin e.m = 5'b10000; e.bg = 0; end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (Rst_n && commit) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got commit=1 expected none (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.m[0]) chk($sformatf("f%0d_x0", mon_e.f), int'(x0), int'(mon_e.x0));
        if (mon_e.m[1]) chk($sformatf("f%0d_x1", mon_e.f), int'(x1), int'(mon_e.x1));
        if (mon_e.m[2]) chk($sformatf("f%0d_x2", mon_e.f), int'(x2), int'(mon_e.x2));
        if (mon_e.m[3]) chk($sformatf("f%0d_hit", mon_e.f), int'(hit_count), int'(mon_e.hit));
        if (mon_e.m[4]) chk($sformatf("f%0d_bg", mon_e.f), int'(bg_state), int'(mon_e.bg));
        chk($sformatf("f%0d_busy_at_commit", mon_e.f), int'(busy), 0);
      end
    end
  end

  task automatic tick_pulse();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0;
    frame_tick = 1'b0;
    run = 1'b1;
    repeat (3) @(negedge clk);
    Rst_n = 1'b1;

    // Idle with run=1 and no ticks.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0 || i == 19) begin
        chk("idle_x0", int'(x0), 11);
        chk("idle_x1", int'(x1), 101);
        chk("idle_x2", int'(x2), 201);
        chk("idle_bg", int'(bg_state), 0);
        chk("idle_hit", int'(hit_count), 0);
        chk("idle_ovr", int'(overrun), 0);
      end
      chk("idle_busy", int'(busy), 0);
      chk("idle_commit", int'(commit), 0);
    end

    // Frame 1 with detailed timing.
    q.push_back(exp_for(1));
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      chk($sformatf("f1_busy_c%0d", k), int'(busy), 1);
      chk($sformatf("f1_commit_c%0d", k), int'(commit), 0);
      chk($sformatf("f1_hold_x0_c%0d", k), int'(x0), 11);
      chk($sformatf("f1_hold_x2_c%0d", k), int'(x2), 201);
    end
    @(negedge clk);
    chk("f1_commit_edge", int'(commit), 1);
    @(negedge clk);
    chk("f1_commit_pulse", int'(commit), 0);
    wait_drain();

    for (int f = 2; f <= 180; f++) begin
      if (f == 34) begin
        chk("ovr_before", int'(overrun), 0);
        q.push_back(exp_for(f));
        tick_pulse();
        tick_pulse();
        repeat (8) @(negedge clk);
        chk("ovr_after", int'(overrun), 1);
      end else begin
        q.push_back(exp_for(f));
        tick_pulse();
        repeat (7) @(negedge clk);
      end
      wait_drain();
    end

    // Reset during UPD1: nothing may commit.
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk) Rst_n = 1'b0;
    @(negedge clk);
    Rst_n = 1'b1;
    chk("rst_x0", int'(x0), 11);
    chk("rst_x1", int'(x1), 101);
    chk("rst_x2", int'(x2), 201);
    chk("rst_bg", int'(bg_state), 0);
    chk("rst_hit", int'(hit_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_commit", int'(commit), 0);
    chk("rst_ovr", int'(overrun), 0);
    repeat (10) @(negedge clk);

    // run=0: ticks ignored.
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_pulse();
      chk("norun_busy", int'(busy), 0);
      repeat (7) @(negedge clk);
      chk("norun_x0", int'(x0), 11);
      chk("norun_ovr", int'(overrun), 0);
    end
    run = 1'b1;

    // After reset the first frame restarts from the initial positions.
    q.push_back(exp_for(1));
    tick_pulse();
    repeat (7) @(negedge clk);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
